// File: rtl/rxuart_pkg.sv
// rxuart_pkg: shared state encoding and default baud divisor for the UART receiver.
package rxuart_pkg;

  // 115200 baud from a 25 MHz clock
  localparam int DEFAULT_CLOCKS_PER_BAUD = 217;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START      = 3'd1,
    DATA       = 3'd2,
    STOP       = 3'd3,
    BREAK_WAIT = 3'd4
  } rx_state_t;

endpackage

// File: rtl/rxuart_sync2.sv
// sync2: two-flop synchronizer for bringing the asynchronous serial line into the clk domain.
module sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops; both preset to the line's idle level on reset
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/rxuart.sv
// rxuart: 8N1 UART receiver, LSB first, mid-bit sampling with a down-counting baud timer.
// Optional feature: define RXUART_FRAME_ERR_EN to get the o_frame_err strobe on a bad stop bit.
module rxuart
  import rxuart_pkg::*;
#(
  parameter int CLOCKS_PER_BAUD = DEFAULT_CLOCKS_PER_BAUD
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_uart_rx,
  output logic       o_wr,
  output logic [7:0] o_data,
`ifdef RXUART_FRAME_ERR_EN
  output logic       o_frame_err,
`endif
  output logic       o_busy
);

  localparam int CNT_W = $clog2(CLOCKS_PER_BAUD);
  // Loaded values are one less than the wait because the sample happens when the counter reads zero
  localparam logic [CNT_W-1:0] BAUD_RELOAD = CNT_W'(CLOCKS_PER_BAUD - 1);
  localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(CLOCKS_PER_BAUD / 2 - 1);

  rx_state_t        state;
  logic [CNT_W-1:0] counter;
  logic [2:0]       bit_idx;
  logic [7:0]       shift_reg;
  logic             rx_s;

  sync2 #(
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk   (i_clk),
    .reset (i_reset),
    .d     (i_uart_rx),
    .q     (rx_s)
  );

  // Frame FSM: hunt for start, sample each bit at its centre, and leave at mid-stop so a back-to-back start is caught
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state     <= IDLE;
      counter   <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      o_wr      <= 1'b0;
      o_busy    <= 1'b0;
      o_data    <= 8'h00;
`ifdef RXUART_FRAME_ERR_EN
      o_frame_err <= 1'b0;
`endif
    end else begin
      o_wr <= 1'b0;
`ifdef RXUART_FRAME_ERR_EN
      o_frame_err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (!rx_s) begin
            state   <= START;
            counter <= HALF_RELOAD;
            o_busy  <= 1'b1;
          end
        end
        START: begin
          if (counter != '0) begin
            counter <= counter - 1'b1;
          end else if (!rx_s) begin
            state   <= DATA;
            counter <= BAUD_RELOAD;
            bit_idx <= '0;
          end else begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end
        end
        DATA: begin
          if (counter != '0) begin
            counter <= counter - 1'b1;
          end else begin
            shift_reg <= {rx_s, shift_reg[7:1]};
            counter   <= BAUD_RELOAD;
            if (bit_idx == 3'd7) begin
              state   <= STOP;
              bit_idx <= '0;
            end else begin
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
        STOP: begin
          if (counter != '0) begin
            counter <= counter - 1'b1;
          end else if (rx_s) begin
            o_wr   <= 1'b1;
            o_data <= shift_reg;
            state  <= IDLE;
            o_busy <= 1'b0;
          end else begin
`ifdef RXUART_FRAME_ERR_EN
            o_frame_err <= 1'b1;
`endif
            state  <= BREAK_WAIT;
            o_busy <= 1'b0;
          end
        end
        BREAK_WAIT: begin
          if (rx_s) begin
            state <= IDLE;
          end
        end
        default: begin
          state  <= IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rxuart.sv
// tb_rxuart: randomized and directed serial frames checked against a queue of expected bytes.
module tb_rxuart;

  localparam int CPB = 217;

  logic       clk = 1'b0;
  logic       reset;
  logic       uart_rx;
  logic       wr;
  logic [7:0] data;
  logic       busy;
`ifdef RXUART_FRAME_ERR_EN
  logic       frame_err;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  // Reference model: bytes the line carried with a good stop bit, in order
  logic [7:0] exp_q[$];
  int      wr_count      = 0;
  int      err_count     = 0;
  int      unexpected_wr = 0;
  longint  cycle         = 0;
  longint  last_wr       = 0;
  longint  prev_wr       = 0;

  rxuart #(
    .CLOCKS_PER_BAUD (CPB)
  ) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_uart_rx   (uart_rx),
    .o_wr        (wr),
    .o_data      (data),
`ifdef RXUART_FRAME_ERR_EN
    .o_frame_err (frame_err),
`endif
    .o_busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor on the falling edge: every write strobe is matched against the next expected byte
  always @(negedge clk) begin
    cycle++;
    if (wr === 1'b1) begin
      wr_count++;
      prev_wr = last_wr;
      last_wr = cycle;
      if (exp_q.size() != 0) check_output("rx_byte", 32'(data), 32'(exp_q.pop_front()));
      else unexpected_wr++;
    end
`ifdef RXUART_FRAME_ERR_EN
    if (frame_err === 1'b1) err_count++;
`endif
  end

  // Line driving helpers start and end one time unit after a rising edge
  task automatic hold_line(input logic v, input int n);
    uart_rx = v;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] b, input logic stop_val);
    if (stop_val) exp_q.push_back(b);
    hold_line(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold_line(b[i], CPB);
    hold_line(stop_val, CPB);
  endtask

  initial begin
    int w0;
    int e0;
    logic got_busy;
    logic [7:0] last_rand;

    reset   = 1'b1;
    uart_rx = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_output("reset_wr",   32'(wr),   32'd0);
    check_output("reset_busy", 32'(busy), 32'd0);
    check_output("reset_data", 32'(data), 32'h00);
    @(posedge clk);
    #1;
    hold_line(1'b1, 20);

    // "He" sent back-to-back
    w0 = wr_count;
    e0 = err_count;
    apply_stimulus(8'h48, 1'b1);
    apply_stimulus(8'h65, 1'b1);
    hold_line(1'b1, CPB);
    check_output("he_wr_count", 32'(wr_count - w0), 32'd2);
    check_output("he_data",     32'(data),          32'h65);
    check_output("he_no_err",   32'(err_count - e0), 32'd0);

    // Short low glitch: busy must assert, then drop at the half-bit check
    w0 = wr_count;
    got_busy = 1'b0;
    uart_rx = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (busy === 1'b1) got_busy = 1'b1;
      @(posedge clk);
      #1;
    end
    hold_line(1'b1, 150);
    check_output("glitch_busy_seen", 32'(got_busy), 32'd1);
    check_output("glitch_busy_fall", 32'(busy),     32'd0);
    check_output("glitch_no_wr",     32'(wr_count - w0), 32'd0);

    // Bad stop followed by a long break, then recovery
    w0 = wr_count;
    e0 = err_count;
    apply_stimulus(8'hA5, 1'b0);
    hold_line(1'b0, 20 * CPB);
    check_output("brk_busy",  32'(busy),         32'd0);
    check_output("brk_no_wr", 32'(wr_count - w0), 32'd0);
    check_output("brk_data_held", 32'(data),     32'h65);
`ifdef RXUART_FRAME_ERR_EN
    check_output("brk_one_err", 32'(err_count - e0), 32'd1);
`endif
    hold_line(1'b1, 2 * CPB);
    apply_stimulus(8'h3C, 1'b1);
    hold_line(1'b1, CPB);
    check_output("brk_recover_wr",   32'(wr_count - w0), 32'd1);
    check_output("brk_recover_data", 32'(data),          32'h3C);

    // One-cycle reset during bit 4 of 0xFF
    w0 = wr_count;
    hold_line(1'b0, CPB);
    for (int i = 0; i < 4; i++) hold_line(1'b1, CPB);
    hold_line(1'b1, CPB / 2);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_output("rst_mid_busy", 32'(busy), 32'd0);
    check_output("rst_mid_data", 32'(data), 32'h00);
    @(posedge clk);
    #1;
    hold_line(1'b1, 5 * CPB);
    check_output("rst_mid_no_wr", 32'(wr_count - w0), 32'd0);
    apply_stimulus(8'h11, 1'b1);
    hold_line(1'b1, CPB);
    check_output("rst_next_data", 32'(data),          32'h11);
    check_output("rst_next_wr",   32'(wr_count - w0), 32'd1);

    // Minimum stop bit with no idle gap between frames
    w0 = wr_count;
    apply_stimulus(8'h00, 1'b1);
    apply_stimulus(8'hFF, 1'b1);
    hold_line(1'b1, CPB);
    check_output("b2b_wr_count", 32'(wr_count - w0),   32'd2);
    check_output("b2b_spacing",  32'(last_wr - prev_wr), 32'(10 * CPB));
    check_output("b2b_data",     32'(data),            32'hFF);

    // Random bytes with random idle gaps (zero gap allowed)
    w0 = wr_count;
    last_rand = 8'h00;
    for (int n = 0; n < 10; n++) begin
      last_rand = 8'($urandom_range(0, 255));
      apply_stimulus(last_rand, 1'b1);
      hold_line(1'b1, int'($urandom_range(0, CPB)));
    end
    hold_line(1'b1, CPB);
    check_output("rand_wr_count",  32'(wr_count - w0), 32'd10);
    check_output("rand_last_data", 32'(data),          32'(last_rand));
    check_output("queue_drained",  32'(exp_q.size()),  32'd0);
    check_output("unexpected_wr",  32'(unexpected_wr), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/rxuart.md
RXUART -- requirements
Module: rxuart

Interface
REQ-001 SHALL have parameter CLOCKS_PER_BAUD, default 217, meaning i_clk cycles per UART bit (115200 baud at 25 MHz); legal range 16..65535.
REQ-002 SHALL have port i_clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-003 SHALL have port i_reset, input, 1, meaning the reset, which is synchronous and active-high.
REQ-004 SHALL have port i_uart_rx, input, 1, meaning the asynchronous serial line (8N1, idle high, LSB first).
REQ-005 SHALL have port o_wr, output, 1, meaning a one-cycle strobe that a valid byte is on o_data.
REQ-006 SHALL have port o_data, output, 8, meaning the last received byte, held until the next valid byte.
REQ-007 SHALL have port o_busy, output, 1, meaning a frame is in progress (START, DATA or STOP).
REQ-008 SHALL have port o_frame_err, output, 1, meaning a one-cycle strobe on a bad stop bit, present only when RXUART_FRAME_ERR_EN is defined.

Function
REQ-009 SHALL pass i_uart_rx through a 2-flop synchronizer; only its output (rx_s) is sampled.
REQ-010 SHALL implement states IDLE, START, DATA, STOP and BREAK_WAIT.
REQ-011 IDLE: when rx_s=0, SHALL go to START and load the baud counter so the next sample falls CLOCKS_PER_BAUD/2 (integer division) cycles later.
REQ-012 START: at the half-bit sample, if rx_s=0 SHALL go to DATA with counter=CLOCKS_PER_BAUD-1; if rx_s=1 (glitch) SHALL return to IDLE with no strobe.
REQ-013 DATA: SHALL sample rx_s every CLOCKS_PER_BAUD cycles, shifting LSB first, for exactly 8 bits, then go to STOP.
REQ-014 STOP: at mid-stop sample, if rx_s=1 SHALL pulse o_wr for one cycle on the next edge, update o_data in that same cycle, and go to IDLE.
REQ-015 STOP with rx_s=0 SHALL NOT pulse o_wr or change o_data; it SHALL pulse o_frame_err (if enabled) and go to BREAK_WAIT.
REQ-016 BREAK_WAIT: SHALL remain until rx_s=1, then go to IDLE; a held-low line yields exactly one error per break.
REQ-017 Returning to IDLE at mid-stop SHALL allow a start bit that immediately follows a minimum-length stop bit to be detected.
REQ-018 o_busy SHALL be 1 exactly in START, DATA and STOP, and 0 in IDLE and BREAK_WAIT.
REQ-019 Baud counter SHALL be $clog2(CLOCKS_PER_BAUD) bits, counts down, and SHALL NOT wrap within a bit.

Reset
REQ-020 i_reset=1 SHALL force on the next edge: state=IDLE, synchronizer flops=1, counter=0, bit index=0, o_wr=0, o_busy=0, o_frame_err=0, o_data=8'h00.
REQ-021 Reset mid-frame SHALL abort the frame with no o_wr; reset SHALL dominate all other events in the same cycle.

Configuration
REQ-022 Macro RXUART_FRAME_ERR_EN defined: o_frame_err port and logic SHALL exist per REQ-015.
REQ-023 Macro RXUART_FRAME_ERR_EN undefined: the port SHALL be absent; bad-stop behaviour (no o_wr, BREAK_WAIT) SHALL be unchanged.

Structure
REQ-024 A shared package rxuart_pkg SHALL hold the state encoding constants (3-bit) and the default CLOCKS_PER_BAUD value.
REQ-025 A sub-module sync2 (2-flop synchronizer, reset value parameter) SHALL implement REQ-009; all other logic stays in rxuart.

Verification
REQ-026 Loopback from txuart (CLOCKS_PER_BAUD=217) sending "H" then "e" back-to-back -> two o_wr pulses, o_data=8'h48 then 8'h65, no o_frame_err.
REQ-027 i_uart_rx low for 50 cycles, then high -> o_busy rises then falls before bit 0, no o_wr, state IDLE.
REQ-028 Frame 8'hA5 with stop bit driven low, line then held low for 20 bit times -> no o_wr, exactly one o_frame_err pulse, o_busy=0; after line goes high, a following 8'h3C is received correctly.
REQ-029 i_reset asserted for 1 cycle at bit 4 of 8'hFF -> o_busy=0 on the next edge, no o_wr, o_data=8'h00; the next full frame 8'h11 is received.
REQ-030 Frame 8'h00 and frame 8'hFF, each with a stop bit of exactly CLOCKS_PER_BAUD cycles and no idle gap -> both bytes received, o_wr pulses ~10*217 cycles apart.
